// File: rtl/fetch_pkg.sv
// Shared defaults and encodings for the fetch stage: PC/immediate/instruction
// widths, the bubble instruction, and the next-PC source selection.
package fetch_pkg;

   localparam int PC_W_DEF    = 6;
   localparam int IMM_W_DEF   = 4;
   localparam int INSTR_W_DEF = 16;
   localparam int SHIFT_DEF   = 1;

   localparam logic [INSTR_W_DEF-1:0] NOP = '0;

   typedef enum logic [1:0] {
      NPC_SEQ      = 2'd0,
      NPC_HOLD     = 2'd1,
      NPC_REDIRECT = 2'd2
   } npc_sel_e;

   // A resolved branch redirects even when the hazard unit asks for a hold.
   function automatic npc_sel_e npc_select(input logic taken, input logic haz);
      npc_sel_e sel;
      if (taken)
         sel = NPC_REDIRECT;
      else if (haz)
         sel = NPC_HOLD;
      else
         sel = NPC_SEQ;
      return sel;
   endfunction

endpackage

// File: rtl/branch_tgt_calc.sv
// Branch target adder: PC+1 of the branch plus the sign-extended, scaled
// immediate, wrapping modulo 2^PC_W.
module branch_tgt_calc
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IMM_W = IMM_W_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic [PC_W-1:0]  br_pc,
   input  logic [IMM_W-1:0] br_imm,
   output logic [PC_W-1:0]  br_target
);

   function automatic logic signed [PC_W-1:0] sext_shift(input logic [IMM_W-1:0] imm);
      logic signed [PC_W-1:0] sx;
      sx = PC_W'($signed(imm));
      return sx <<< SHIFT;
   endfunction

   logic signed [PC_W-1:0] offset;

   assign offset    = sext_shift(br_imm);
   assign br_target = br_pc + $unsigned(offset);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage control: PC register, IF/ID pipeline register and the flush
// pulse, with branch redirect taking priority over a hazard hold.
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              IMM_W    = IMM_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter int              SHIFT    = SHIFT_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               CLOCK,
   input  logic               in_rst,
   input  logic               in_haz,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_br_cntrl,
   input  logic               in_comp,
   input  logic [PC_W-1:0]    in_br_pc,
   input  logic [IMM_W-1:0]   in_br_imm,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc1,
   output logic               out_valid,
   output logic               out_taken,
   output logic [PC_W-1:0]    out_br_target,
   output logic               flush_out
);

   logic [PC_W-1:0]    pc_p0;
   logic [INSTR_W-1:0] instr_p1;
   logic [PC_W-1:0]    pc1_p1;
   logic               vld_p1;
   logic               flush_p1;

   logic               taken;
   logic [PC_W-1:0]    br_target;
   logic [PC_W-1:0]    pc_inc;
   npc_sel_e           npc_sel;

   logic [PC_W-1:0]    pc_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic [PC_W-1:0]    pc1_nxt;
   logic               vld_nxt;
   logic               flush_nxt;

   branch_tgt_calc #(
      .PC_W  (PC_W),
      .IMM_W (IMM_W),
      .SHIFT (SHIFT)
   ) u_tgt (
      .br_pc     (in_br_pc),
      .br_imm    (in_br_imm),
      .br_target (br_target)
   );

   assign taken   = in_br_cntrl & in_comp;
   assign pc_inc  = pc_p0 + PC_W'(1);
   assign npc_sel = npc_select(taken, in_haz);

   always_comb begin
      pc_nxt    = pc_inc;
      instr_nxt = in_instr;
      pc1_nxt   = pc_inc;
      vld_nxt   = 1'b1;
      flush_nxt = 1'b0;
      case (npc_sel)
         NPC_REDIRECT: begin
            pc_nxt    = br_target;
            instr_nxt = INSTR_W'(NOP);
            pc1_nxt   = '0;
            vld_nxt   = 1'b0;
            flush_nxt = 1'b1;
         end
         NPC_HOLD: begin
            pc_nxt    = pc_p0;
            instr_nxt = instr_p1;
            pc1_nxt   = pc1_p1;
            vld_nxt   = vld_p1;
         end
         default: ;
      endcase
   end

   // p0: fetch address
   always_ff @(posedge CLOCK or negedge in_rst) begin
      if (!in_rst)
         pc_p0 <= RESET_PC;
      else
         pc_p0 <= pc_nxt;
   end

   // p1: IF/ID register and flush pulse
   always_ff @(posedge CLOCK or negedge in_rst) begin
      if (!in_rst) begin
         instr_p1 <= '0;
         pc1_p1   <= '0;
         vld_p1   <= 1'b0;
         flush_p1 <= 1'b0;
      end else begin
         instr_p1 <= instr_nxt;
         pc1_p1   <= pc1_nxt;
         vld_p1   <= vld_nxt;
         flush_p1 <= flush_nxt;
      end
   end

   assign pc_out        = pc_p0;
   assign out_instr     = instr_p1;
   assign out_pc1       = pc1_p1;
   assign out_valid     = vld_p1;
   assign flush_out     = flush_p1;
   assign out_taken     = taken;
   assign out_br_target = br_target;

endmodule
